// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter in front of the single core memory interface. Port 0
// is the CPU, port 1 a second master (DMA, debug). In IDLE the arbiter picks a
// winner: a lone requester wins outright, and a simultaneous pair is broken by
// a round-robin pointer that favours the port not granted last (port 0 after
// reset). The winner's address/access/write data are registered onto the
// mem_* outputs and held stable until mem_ack. The ack is returned to the owner
// combinationally in the ack cycle. A transaction that sees no mem_ack for
// TIMEOUT busy cycles is aborted with a one-cycle req_err pulse to the owner.
//
// Parameters
//   XLEN      data width of one word
//   PLEN      physical address width
//   ACCESS_W  width of the access-type encoding (passed through opaquely)
//   TIMEOUT   busy cycles without mem_ack before abort; 0 disables the abort
//
// Ports
//   clock         single clock, rising edge
//   reset_n       asynchronous active-low reset
//   req_cycle     per-port request valid (bit i = port i)
//   req_paddr     per-port physical address
//   req_access    per-port access type
//   req_data_out  per-port write data
//   req_data_in   read line, broadcast to both ports (valid with req_ack)
//   req_ack       per-port completion pulse
//   req_err       per-port timeout abort pulse
//   grant         one-hot owner of the current transaction, 0 when IDLE
//   mem_cycle     downstream request valid
//   mem_paddr     downstream address
//   mem_access    downstream access type
//   mem_data_out  downstream write data
//   mem_data_in   downstream read line
//   mem_ack       downstream completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int PLEN     = 34,
  parameter int ACCESS_W = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     clock,
  input  logic                     reset_n,

  input  logic [1:0]               req_cycle,
  input  logic [1:0][PLEN-1:0]     req_paddr,
  input  logic [1:0][ACCESS_W-1:0] req_access,
  input  logic [1:0][XLEN-1:0]     req_data_out,
  output logic [4*XLEN-1:0]        req_data_in,
  output logic [1:0]               req_ack,
  output logic [1:0]               req_err,
  output logic [1:0]               grant,

  output logic                     mem_cycle,
  output logic [PLEN-1:0]          mem_paddr,
  output logic [ACCESS_W-1:0]      mem_access,
  output logic [XLEN-1:0]          mem_data_out,
  input  logic [4*XLEN-1:0]        mem_data_in,
  input  logic                     mem_ack
);

  // A disabled timeout still gets a 1-bit counter so every width stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             prio;      // port that wins a simultaneous request
  logic [1:0]       req_live;
  logic             win;
  logic             owner;
  logic             tmo_hit;

  // A port whose error pulse is showing still holds req_cycle for this one
  // cycle (it drops on the next edge); masking it keeps the aborted request
  // from being re-granted as if it were new.
  assign req_live = req_cycle & ~req_err;

  always_comb begin
    win = prio;
    case (req_live)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = prio;
    endcase
  end

  assign owner = grant[1];

  // Abort fires in the TIMEOUT-th busy cycle; an ack in that same cycle wins.
  assign tmo_hit = (TIMEOUT > 0) && (state == S_BUSY) && !mem_ack && (cnt == CNT_LAST);

  assign req_ack     = (state == S_BUSY && mem_ack) ? grant : 2'b00;
  assign req_data_in = mem_data_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      grant        <= 2'b00;
      prio         <= 1'b0;
      cnt          <= '0;
      req_err      <= 2'b00;
      mem_cycle    <= 1'b0;
      mem_paddr    <= '0;
      mem_access   <= '0;
      mem_data_out <= '0;
    end else begin
      req_err <= 2'b00;
      case (state)
        S_IDLE: begin
          if (|req_live) begin
            state        <= S_BUSY;
            mem_cycle    <= 1'b1;
            grant        <= win ? 2'b10 : 2'b01;
            mem_paddr    <= req_paddr[win];
            mem_access   <= req_access[win];
            mem_data_out <= req_data_out[win];
            cnt          <= '0;
          end
        end
        S_BUSY: begin
          if (mem_ack || tmo_hit) begin
            state     <= S_IDLE;
            mem_cycle <= 1'b0;
            grant     <= 2'b00;
            prio      <= ~owner;
            cnt       <= '0;
            if (!mem_ack) begin
              req_err <= grant;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int XLEN     = 32;
  localparam int PLEN     = 34;
  localparam int ACCESS_W = 4;
  localparam int TIMEOUT  = 8;

  localparam int K_GRANT = 0;
  localparam int K_ACK   = 1;
  localparam int K_ERR   = 2;
  localparam int K_NONE  = 3;

  logic                     clock;
  logic                     reset_n;
  logic [1:0]               req_cycle;
  logic [1:0][PLEN-1:0]     req_paddr;
  logic [1:0][ACCESS_W-1:0] req_access;
  logic [1:0][XLEN-1:0]     req_data_out;
  logic [4*XLEN-1:0]        req_data_in;
  logic [1:0]               req_ack;
  logic [1:0]               req_err;
  logic [1:0]               grant;
  logic                     mem_cycle;
  logic [PLEN-1:0]          mem_paddr;
  logic [ACCESS_W-1:0]      mem_access;
  logic [XLEN-1:0]          mem_data_out;
  logic [4*XLEN-1:0]        mem_data_in;
  logic                     mem_ack;

  mem_arbiter #(
    .XLEN(XLEN), .PLEN(PLEN), .ACCESS_W(ACCESS_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_cycle(req_cycle), .req_paddr(req_paddr), .req_access(req_access),
    .req_data_out(req_data_out), .req_data_in(req_data_in),
    .req_ack(req_ack), .req_err(req_err), .grant(grant),
    .mem_cycle(mem_cycle), .mem_paddr(mem_paddr), .mem_access(mem_access),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_ack(mem_ack)
  );

  typedef struct {
    int                  kind;
    logic [1:0]          who;
    logic [PLEN-1:0]     addr;
    logic [ACCESS_W-1:0] acc;
    logic [XLEN-1:0]     wd;
    logic [4*XLEN-1:0]   line;
    int                  len;
  } exp_t;

  exp_t sb[$];

  int n_checks;
  int n_err;

  int                     lat_p [2];
  logic [1:0][4*XLEN-1:0] line_p;
  logic                   stray_ack;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setup(input bit p, input logic [PLEN-1:0] a, input logic [ACCESS_W-1:0] acc,
                       input logic [XLEN-1:0] wd, input int lat, input logic [4*XLEN-1:0] line);
    req_paddr[p]    = a;
    req_access[p]   = acc;
    req_data_out[p] = wd;
    lat_p[p]        = lat;
    line_p[p]       = line;
  endtask

  // Push the grant event and, unless fin is K_NONE, the closing ack/err event.
  task automatic expect_txn(input bit p, input int fin, input int len);
    exp_t e;
    e.kind = K_GRANT;
    e.who  = p ? 2'b10 : 2'b01;
    e.addr = req_paddr[p];
    e.acc  = req_access[p];
    e.wd   = req_data_out[p];
    e.line = line_p[p];
    e.len  = len;
    sb.push_back(e);
    if (fin != K_NONE) begin
      e.kind = fin;
      sb.push_back(e);
    end
  endtask

  // Requester behaviour: raise the masked ports, drop each one on the edge
  // after its ack/err. Must be called while the arbiter is idle.
  task automatic run_reqs(input logic [1:0] mask, input bit wiggle, input logic [PLEN-1:0] hold_addr);
    logic [1:0] pending;
    logic [1:0] done;
    int cyc;
    pending   = mask;
    req_cycle = mask;
    cyc       = 0;
    while (pending != 2'b00 && cyc < 60) begin
      @(negedge clock);
      if (cyc == 0) check("lat_idle", 128'(mem_cycle), 128'(1'b0));
      if (cyc == 1) check("lat_busy", 128'(mem_cycle), 128'(1'b1));
      if (wiggle && mem_cycle) check("hold_paddr", 128'(mem_paddr), 128'(hold_addr));
      done = pending & (req_ack | req_err);
      @(posedge clock);
      #1;
      req_cycle = req_cycle & ~done;
      pending   = pending & ~done;
      if (wiggle) req_paddr[0] = req_paddr[0] + 34'h4;
      cyc++;
    end
    if (pending != 2'b00) begin
      check("run_reqs_bound", 128'(pending), 128'(2'b00));
      req_cycle = 2'b00;
    end
  endtask

  // Memory model: ack in the lat-th busy cycle of the owner (0 = never).
  initial begin
    int bc;
    bc          = 0;
    mem_ack     = 1'b0;
    mem_data_in = '0;
    forever begin
      @(posedge clock);
      #2;
      if (mem_cycle) begin
        bc++;
        mem_ack     = (lat_p[grant[1]] != 0) && (bc == lat_p[grant[1]]);
        mem_data_in = line_p[grant[1]];
      end else begin
        bc          = 0;
        mem_ack     = stray_ack;
        mem_data_in = {4{32'h5A5A_5A5A}};
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    logic prev_mc;
    int   run_len;
    int   len_exp;
    exp_t e;
    prev_mc = 1'b0;
    run_len = 0;
    len_exp = 0;
    forever begin
      @(negedge clock);
      if (mem_cycle) begin
        run_len++;
      end else begin
        if (prev_mc && len_exp != 0) check("busy_len", 128'(run_len), 128'(len_exp));
        run_len = 0;
      end
      if (mem_cycle && !prev_mc) begin
        if (sb.size() == 0) begin
          check("spurious_grant", 128'(grant), 128'(2'b00));
        end else begin
          e = sb.pop_front();
          check("grant_kind", 128'(K_GRANT), 128'(e.kind));
          check("grant", 128'(grant), 128'(e.who));
          check("mem_paddr", 128'(mem_paddr), 128'(e.addr));
          check("mem_access", 128'(mem_access), 128'(e.acc));
          check("mem_data_out", 128'(mem_data_out), 128'(e.wd));
          len_exp = e.len;
        end
      end
      if (req_ack != 2'b00) begin
        if (sb.size() == 0) begin
          check("spurious_ack", 128'(req_ack), 128'(2'b00));
        end else begin
          e = sb.pop_front();
          check("ack_kind", 128'(K_ACK), 128'(e.kind));
          check("req_ack", 128'(req_ack), 128'(e.who));
          check("req_data_in", req_data_in, e.line);
        end
      end
      if (req_err != 2'b00) begin
        if (sb.size() == 0) begin
          check("spurious_err", 128'(req_err), 128'(2'b00));
        end else begin
          e = sb.pop_front();
          check("err_kind", 128'(K_ERR), 128'(e.kind));
          check("req_err", 128'(req_err), 128'(e.who));
        end
      end
      prev_mc = mem_cycle;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_cycle"}, 128'(mem_cycle), 128'(1'b0));
    check({tag, "_grant"}, 128'(grant), 128'(2'b00));
    check({tag, "_mem_paddr"}, 128'(mem_paddr), 128'(0));
    check({tag, "_mem_access"}, 128'(mem_access), 128'(0));
    check({tag, "_mem_data_out"}, 128'(mem_data_out), 128'(0));
    check({tag, "_req_ack"}, 128'(req_ack), 128'(2'b00));
    check({tag, "_req_err"}, 128'(req_err), 128'(2'b00));
  endtask

  initial begin
    n_checks     = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    req_cycle    = 2'b00;
    req_paddr    = '0;
    req_access   = '0;
    req_data_out = '0;
    stray_ack    = 1'b0;
    lat_p[0]     = 0;
    lat_p[1]     = 0;
    line_p       = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Simultaneous pair after reset: port 0, then port 1, then again 0 and 1.
    setup(1'b0, 34'h0_0000_1000, 4'h1, 32'h1111_0000, 2, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    setup(1'b1, 34'h1_0000_0000, 4'h2, 32'h2222_0000, 3, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    expect_txn(1'b0, K_ACK, 2);
    expect_txn(1'b1, K_ACK, 3);
    run_reqs(2'b11, 1'b0, '0);

    setup(1'b0, 34'h0_0000_2000, 4'h4, 32'h3333_0000, 3, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    setup(1'b1, 34'h1_0000_0100, 4'h5, 32'h4444_0000, 1, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    expect_txn(1'b0, K_ACK, 3);
    expect_txn(1'b1, K_ACK, 1);
    run_reqs(2'b11, 1'b0, '0);

    // Port 0 never acked: abort after 8 busy cycles, then pending port 1 served.
    setup(1'b0, 34'h0_0000_3000, 4'h6, 32'h5555_0000, 0, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
    setup(1'b1, 34'h1_0000_0200, 4'h7, 32'h6666_0000, 2, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    expect_txn(1'b0, K_ERR, 8);
    expect_txn(1'b1, K_ACK, 2);
    run_reqs(2'b11, 1'b0, '0);

    // Single CPU read, ack in the 4th busy cycle.
    setup(1'b0, 34'h0_8000_0040, 4'h3, 32'h0, 4, {32'd4, 32'd3, 32'd2, 32'd1});
    expect_txn(1'b0, K_ACK, 4);
    run_reqs(2'b01, 1'b0, '0);

    // Requester address changes every cycle while busy; mem_paddr must hold.
    setup(1'b0, 34'h0_0000_4000, 4'h8, 32'h7777_0000, 5, {32'h13, 32'h12, 32'h11, 32'h10});
    expect_txn(1'b0, K_ACK, 5);
    run_reqs(2'b01, 1'b1, 34'h0_0000_4000);

    // Ack lands in the same cycle the timeout would fire: ack wins.
    setup(1'b0, 34'h0_0000_5000, 4'h9, 32'h8888_0000, 8, {32'h23, 32'h22, 32'h21, 32'h20});
    expect_txn(1'b0, K_ACK, 8);
    run_reqs(2'b01, 1'b0, '0);

    // Stray mem_ack while idle.
    stray_ack = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("stray_req_ack", 128'(req_ack), 128'(2'b00));
    check("stray_mem_cycle", 128'(mem_cycle), 128'(1'b0));
    @(posedge clock);
    #1 stray_ack = 1'b0;
    @(negedge clock);
    check("stray_after", 128'(mem_cycle), 128'(1'b0));
    @(posedge clock);
    #1;

    // Reset in the middle of a busy transaction.
    setup(1'b0, 34'h0_0000_6000, 4'hA, 32'h9999_0000, 0, {32'h33, 32'h32, 32'h31, 32'h30});
    expect_txn(1'b0, K_NONE, 0);
    req_cycle = 2'b01;
    repeat (3) @(negedge clock);
    check("pre_reset_busy", 128'(mem_cycle), 128'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    setup(1'b0, 34'h0_0000_7000, 4'hB, 32'hAAAA_0000, 2, {32'h43, 32'h42, 32'h41, 32'h40});
    setup(1'b1, 34'h1_0000_0300, 4'hC, 32'hBBBB_0000, 2, {32'h53, 32'h52, 32'h51, 32'h50});
    req_cycle = 2'b11;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    expect_txn(1'b0, K_ACK, 2);
    expect_txn(1'b1, K_ACK, 2);
    run_reqs(2'b11, 1'b0, '0);

    repeat (3) @(posedge clock);
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
